// File: rtl/irq_priority_controller_pkg.sv
// irq_priority_controller_pkg: shared FSM encoding, SREG flag position and vector helper
package irq_priority_controller_pkg;
   localparam int FLAGS_I = 7;
   localparam int ISR_VECTOR_BASE = 3;
   localparam int ISR_VECTOR_STRIDE = 1;
   typedef enum logic [1:0] {IRQ_IDLE = 2'd0, IRQ_REQ = 2'd1, IRQ_SVC = 2'd2} irq_state_t;
   function automatic int vec_addr(input int base, input int stride, input int id);
      return base + id * stride;
   endfunction
endpackage

// File: rtl/irq_priority_controller_encoder.sv
// irq_priority_controller_encoder: lowest-index-first priority encoder
//  req   in   NUM_SRC  request vector
//  valid out  1        any request set
//  id    out  4        index of the lowest set request (0 when none)
module irq_priority_controller_encoder #(
   parameter int NUM_SRC = 3
) (
   input  logic [NUM_SRC-1:0] req,
   output logic               valid,
   output logic [3:0]         id
);
   always_comb begin
      valid = |req;
      id = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (req[i]) id = 4'(i);
   end
endmodule

// File: rtl/irq_priority_controller.sv
// irq_priority_controller: prioritised interrupt request with irq/ack handshake and non-nesting FSM
//  clk        in   clock, rising edge
//  reset      in   asynchronous active-high reset
//  src_flag   in   raw source flags
//  src_mask   in   per-source enables
//  mem_sreg   in   status register (global enable at SREG_I_BIT)
//  irq_ack    in   CPU took the vector
//  reti       in   ISR finished
//  irq        out  registered interrupt request
//  vector     out  ISR address of the winner, held until the next win
//  flag_clr   out  one-cycle one-hot clear of the acked source
//  active_id  out  index of the current/last winner
//  in_service out  high while an ISR runs
module irq_priority_controller
   import irq_priority_controller_pkg::*;
#(
   parameter int                  DATA_WIDTH    = 8,
   parameter int                  I_ADDR_WIDTH  = 10,
   parameter int                  NUM_SRC       = 3,
   parameter int                  VECTOR_BASE   = ISR_VECTOR_BASE,
   parameter int                  VECTOR_STRIDE = ISR_VECTOR_STRIDE,
   parameter logic [NUM_SRC-1:0]  EDGE_MODE     = '0,
   parameter int                  SREG_I_BIT    = FLAGS_I
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_SRC-1:0]      src_flag,
   input  logic [NUM_SRC-1:0]      src_mask,
   input  logic [DATA_WIDTH-1:0]   mem_sreg,
   input  logic                    irq_ack,
   input  logic                    reti,
   output logic                    irq,
   output logic [I_ADDR_WIDTH-1:0] vector,
   output logic [NUM_SRC-1:0]      flag_clr,
   output logic [3:0]              active_id,
   output logic                    in_service
);
   irq_state_t state, state_n;
   logic [NUM_SRC-1:0] hist, pend_q, pending, eligible, sel, ack_clr, clr_n;
   logic [I_ADDR_WIDTH-1:0] vector_n;
   logic [3:0] win, id_n;
   logic valid, irq_n, svc_n;
   // only the global-enable bit of SREG is used
   logic unused_sreg;
   assign unused_sreg = ^mem_sreg;
   // edge sources come from the latch, level sources straight from the flag
   assign pending = pend_q | (~EDGE_MODE & src_flag);
   assign eligible = pending & src_mask & {NUM_SRC{mem_sreg[SREG_I_BIT]}};
   assign sel = NUM_SRC'(1) << active_id;
   irq_priority_controller_encoder #(.NUM_SRC(NUM_SRC)) u_enc (
      .req   (eligible),
      .valid (valid),
      .id    (win)
   );
   always_comb begin
      state_n = state;
      irq_n = irq;
      vector_n = vector;
      id_n = active_id;
      svc_n = in_service;
      clr_n = '0;
      ack_clr = '0;
      case (state)
         IRQ_IDLE: if (valid) begin
            irq_n = 1'b1;
            vector_n = I_ADDR_WIDTH'(vec_addr(VECTOR_BASE, VECTOR_STRIDE, int'(win)));
            id_n = win;
            state_n = IRQ_REQ;
         end
         IRQ_REQ: if (irq_ack) begin
            irq_n = 1'b0;
            clr_n = sel;
            ack_clr = sel;
            svc_n = 1'b1;
            state_n = IRQ_SVC;
         end else if (~|(eligible & sel)) begin
            irq_n = 1'b0;
            state_n = IRQ_IDLE;
         end
         IRQ_SVC: begin
            irq_n = 1'b0;
            if (reti) begin
               svc_n = 1'b0;
               state_n = IRQ_IDLE;
            end
         end
         default: state_n = IRQ_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IRQ_IDLE;
         irq <= 1'b0;
         vector <= '0;
         active_id <= '0;
         flag_clr <= '0;
         in_service <= 1'b0;
         hist <= '0;
         pend_q <= '0;
      end else begin
         state <= state_n;
         irq <= irq_n;
         vector <= vector_n;
         active_id <= id_n;
         flag_clr <= clr_n;
         in_service <= svc_n;
         hist <= src_flag;
         // a new rising edge beats a same-cycle clear so the event is kept
         pend_q <= EDGE_MODE & ((src_flag & ~hist) | (pend_q & ~ack_clr));
      end
   end
endmodule

// File: tb/tb_irq_priority_controller.sv
// tb_irq_priority_controller: directed vector table plus edge-mode and async-reset sequences
module tb_irq_priority_controller;
   logic clk = 1'b0;
   logic reset;
   logic [2:0] src_flag, src_mask;
   logic [7:0] mem_sreg;
   logic irq_ack, reti;
   logic irq_a, svc_a, irq_b, svc_b;
   logic [9:0] vec_a, vec_b;
   logic [2:0] clr_a, clr_b;
   logic [3:0] id_a, id_b;
   int n_chk = 0;
   int n_fail = 0;
   typedef struct {
      logic [2:0] flag;
      logic [2:0] mask;
      logic       i;
      logic       ack;
      logic       ret;
      logic       irq;
      int         vec;
      logic [2:0] clr;
      logic       svc;
      int         id;
   } row_t;
   row_t tbl[$];
   always #5 clk = ~clk;
   irq_priority_controller dut_a (
      .clk(clk), .reset(reset), .src_flag(src_flag), .src_mask(src_mask), .mem_sreg(mem_sreg),
      .irq_ack(irq_ack), .reti(reti), .irq(irq_a), .vector(vec_a), .flag_clr(clr_a),
      .active_id(id_a), .in_service(svc_a)
   );
   irq_priority_controller #(.EDGE_MODE(3'b001)) dut_b (
      .clk(clk), .reset(reset), .src_flag(src_flag), .src_mask(src_mask), .mem_sreg(mem_sreg),
      .irq_ack(irq_ack), .reti(reti), .irq(irq_b), .vector(vec_b), .flag_clr(clr_b),
      .active_id(id_b), .in_service(svc_b)
   );
   task automatic chk(input string n, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endtask
   task automatic add(input logic [2:0] f, input logic [2:0] m, input logic i, input logic a,
                      input logic r, input logic q, input int v, input logic [2:0] c,
                      input logic s, input int d);
      row_t x;
      x.flag = f; x.mask = m; x.i = i; x.ack = a; x.ret = r;
      x.irq = q; x.vec = v; x.clr = c; x.svc = s; x.id = d;
      tbl.push_back(x);
   endtask
   task automatic step(input logic [2:0] f, input logic [2:0] m, input logic i, input logic a, input logic r);
      @(negedge clk);
      src_flag = f; src_mask = m; mem_sreg = {i, 7'b0}; irq_ack = a; reti = r;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      src_flag = '0; src_mask = '0; mem_sreg = '0; irq_ack = 1'b0; reti = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask
   task automatic chk_b(input string n, input logic q, input int v, input logic [2:0] c, input logic s);
      chk({n, " irq"}, int'(irq_b), int'(q));
      chk({n, " vector"}, int'(vec_b), v);
      chk({n, " flag_clr"}, int'(clr_b), int'(c));
      chk({n, " in_service"}, int'(svc_b), int'(s));
   endtask
   initial begin
      reset = 1'b1;
      src_flag = '0; src_mask = '0; mem_sreg = '0; irq_ack = 1'b0; reti = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset irq", int'(irq_a), 0);
      chk("reset vector", int'(vec_a), 0);
      chk("reset flag_clr", int'(clr_a), 0);
      chk("reset active_id", int'(id_a), 0);
      chk("reset in_service", int'(svc_a), 0);
      @(negedge clk);
      reset = 1'b0;
      //   flag    mask    I     ack   reti  | irq  vec clr     svc   id
      add(3'b001, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 3, 3'b000, 1'b0, 0);
      add(3'b001, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 3, 3'b001, 1'b1, 0);
      add(3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 3, 3'b000, 1'b1, 0);
      add(3'b000, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 3, 3'b000, 1'b0, 0);
      add(3'b110, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 4, 3'b000, 1'b0, 1);
      add(3'b110, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 4, 3'b010, 1'b1, 1);
      add(3'b100, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 4, 3'b000, 1'b1, 1);
      add(3'b100, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 4, 3'b000, 1'b0, 1);
      add(3'b100, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 5, 3'b000, 1'b0, 2);
      add(3'b101, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 5, 3'b000, 1'b0, 2);
      add(3'b101, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 5, 3'b100, 1'b1, 2);
      add(3'b001, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 5, 3'b000, 1'b1, 2);
      add(3'b001, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 5, 3'b000, 1'b0, 2);
      add(3'b001, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 3, 3'b000, 1'b0, 0);
      add(3'b001, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 3, 3'b001, 1'b1, 0);
      add(3'b000, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 3, 3'b000, 1'b0, 0);
      add(3'b001, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 3, 3'b000, 1'b0, 0);
      add(3'b001, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 3, 3'b000, 1'b0, 0);
      add(3'b001, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 3, 3'b000, 1'b0, 0);
      add(3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3, 3'b000, 1'b0, 0);
      add(3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3, 3'b000, 1'b0, 0);
      add(3'b001, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 3, 3'b000, 1'b0, 0);
      add(3'b001, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 3, 3'b000, 1'b0, 0);
      add(3'b010, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 4, 3'b000, 1'b0, 1);
      add(3'b000, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 4, 3'b010, 1'b1, 1);
      add(3'b000, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 4, 3'b000, 1'b0, 1);
      foreach (tbl[k]) begin
         step(tbl[k].flag, tbl[k].mask, tbl[k].i, tbl[k].ack, tbl[k].ret);
         chk($sformatf("row%0d irq", k), int'(irq_a), int'(tbl[k].irq));
         chk($sformatf("row%0d vector", k), int'(vec_a), tbl[k].vec);
         chk($sformatf("row%0d flag_clr", k), int'(clr_a), int'(tbl[k].clr));
         chk($sformatf("row%0d in_service", k), int'(svc_a), int'(tbl[k].svc));
         chk($sformatf("row%0d active_id", k), int'(id_a), tbl[k].id);
      end
      do_reset();
      step(3'b001, 3'b111, 1'b1, 1'b0, 1'b0); chk_b("edge latch", 1'b0, 0, 3'b000, 1'b0);
      step(3'b001, 3'b111, 1'b1, 1'b0, 1'b0); chk_b("edge req", 1'b1, 3, 3'b000, 1'b0);
      step(3'b001, 3'b111, 1'b1, 1'b1, 1'b0); chk_b("edge ack", 1'b0, 3, 3'b001, 1'b1);
      step(3'b001, 3'b111, 1'b1, 1'b0, 1'b0); chk_b("edge svc", 1'b0, 3, 3'b000, 1'b1);
      step(3'b001, 3'b111, 1'b1, 1'b0, 1'b1); chk_b("edge reti", 1'b0, 3, 3'b000, 1'b0);
      step(3'b001, 3'b111, 1'b1, 1'b0, 1'b0); chk_b("edge held1", 1'b0, 3, 3'b000, 1'b0);
      step(3'b001, 3'b111, 1'b1, 1'b0, 1'b0); chk_b("edge held2", 1'b0, 3, 3'b000, 1'b0);
      step(3'b000, 3'b111, 1'b1, 1'b0, 1'b0); chk_b("edge low", 1'b0, 3, 3'b000, 1'b0);
      step(3'b001, 3'b111, 1'b1, 1'b0, 1'b0); chk_b("edge rise2", 1'b0, 3, 3'b000, 1'b0);
      step(3'b001, 3'b111, 1'b1, 1'b0, 1'b0); chk_b("edge req2", 1'b1, 3, 3'b000, 1'b0);
      step(3'b001, 3'b111, 1'b1, 1'b1, 1'b0); chk_b("edge ack2", 1'b0, 3, 3'b001, 1'b1);
      step(3'b000, 3'b111, 1'b1, 1'b0, 1'b0); chk_b("svc low", 1'b0, 3, 3'b000, 1'b1);
      step(3'b001, 3'b111, 1'b1, 1'b0, 1'b0); chk_b("svc rise", 1'b0, 3, 3'b000, 1'b1);
      step(3'b001, 3'b111, 1'b1, 1'b0, 1'b1); chk_b("svc reti", 1'b0, 3, 3'b000, 1'b0);
      step(3'b001, 3'b111, 1'b1, 1'b0, 1'b0); chk_b("rearb irq", 1'b1, 3, 3'b000, 1'b0);
      step(3'b000, 3'b111, 1'b1, 1'b0, 1'b0); chk_b("req flag low", 1'b1, 3, 3'b000, 1'b0);
      step(3'b001, 3'b111, 1'b1, 1'b1, 1'b0); chk_b("ack+edge", 1'b0, 3, 3'b001, 1'b1);
      step(3'b001, 3'b111, 1'b1, 1'b0, 1'b1); chk_b("ack+edge reti", 1'b0, 3, 3'b000, 1'b0);
      step(3'b001, 3'b111, 1'b1, 1'b0, 1'b0); chk_b("edge kept", 1'b1, 3, 3'b000, 1'b0);
      do_reset();
      step(3'b001, 3'b111, 1'b1, 1'b0, 1'b0);
      chk("pre-reset irq", int'(irq_a), 1);
      step(3'b001, 3'b111, 1'b1, 1'b1, 1'b0);
      chk("pre-reset flag_clr", int'(clr_a), 1);
      chk("pre-reset in_service", int'(svc_a), 1);
      #3 reset = 1'b1;
      #1;
      chk("async irq", int'(irq_a), 0);
      chk("async flag_clr", int'(clr_a), 0);
      chk("async in_service", int'(svc_a), 0);
      chk("async active_id", int'(id_a), 0);
      chk("async vector", int'(vec_a), 0);
      @(negedge clk);
      reset = 1'b0;
      irq_ack = 1'b0;
      @(posedge clk);
      #1;
      chk("post-reset flag_clr", int'(clr_a), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
